// File: rtl/fb_pkg.sv
// Shared framebuffer layout: geometry constants, scan-state encoding and the
// address-composition helper used by both the display reader and the writer.
package fb_pkg;

   localparam int FB_COLS  = 8;
   localparam int FB_LINES = 32;
   localparam int COL_W    = 3;
   localparam int LINE_W   = 5;
   localparam int ADDR_W   = COL_W + LINE_W;

   // Scan sequencer states. The low/high shift-clock phases live inside
   // led_byte_shifter, so the sequencer sees one SHIFT state per byte.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_CAP  = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_LATCH   = 3'd4,
      ST_DWELL   = 3'd5
   } scan_state_t;

   // Physical RAM address: column in the high bits, line in the low bits.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [COL_W-1:0]  col,
                                                 input logic [LINE_W-1:0] line);
      return {col, line};
   endfunction

endpackage

// File: rtl/fb_scan_reader_shifter.sv
// led_byte_shifter: serialises one byte MSB-first onto sdi with a two-cycle
// shift clock (low phase presents data, high phase is the sampling edge).
module led_byte_shifter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       run,
   input  logic [7:0] data,
   output logic       sdi,
   output logic       sclk,
   output logic       last_bit
);

   logic [7:0] shreg_reg, shreg_next;
   logic [2:0] bitcnt_reg, bitcnt_next;
   logic       phase_reg, phase_next;

   // Load a fresh byte, or alternate low/high phases and shift after each high.
   always_comb begin
      shreg_next  = shreg_reg;
      bitcnt_next = bitcnt_reg;
      phase_next  = phase_reg;
      if (load) begin
         shreg_next  = data;
         bitcnt_next = 3'd0;
         phase_next  = 1'b0;
      end else if (run) begin
         if (!phase_reg) begin
            phase_next = 1'b1;
         end else begin
            phase_next  = 1'b0;
            shreg_next  = {shreg_reg[6:0], 1'b0};
            bitcnt_next = bitcnt_reg + 3'd1;
         end
      end
   end

   // Shifter state registers; reset clears the data so sdi idles low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_reg  <= 8'h00;
         bitcnt_reg <= 3'd0;
         phase_reg  <= 1'b0;
      end else begin
         shreg_reg  <= shreg_next;
         bitcnt_reg <= bitcnt_next;
         phase_reg  <= phase_next;
      end
   end

   // Data stays stable across both phases of a bit; the clock is the phase.
   // last_bit is independent of run so the sequencer has no comb loop.
   assign sdi      = shreg_reg[7];
   assign sclk     = phase_reg;
   assign last_bit = phase_reg && (bitcnt_reg == 3'd7);

endmodule

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: reads the 8x32 byte framebuffer one line at a time and
// shifts it out to an LED matrix, holding each latched row for a dwell period.
// Between lines it can park (idle=1) so the RAM port can be handed over.
// Optional build macro FB_SCAN_BLANK_EN blanks the outputs during the latch
// cycle and the first dwell cycle to hide row-change ghosting.
module fb_scan_reader
   import fb_pkg::*;
#(
   parameter int DWELL_CYCLES = 256,
   parameter int DWELL_W      = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic [7:0]        ram_dout,
   output logic              ram_clk,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              led_sdi,
   output logic              led_sclk,
   output logic              led_lat,
   output logic              led_oe_n,
   output logic [LINE_W-1:0] led_row,
   output logic              idle,
   output logic              frame_done
);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(FB_COLS - 1);
   localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(FB_LINES - 1);

   scan_state_t        state_reg, state_next;
   logic [COL_W-1:0]   col_reg, col_next;
   logic [LINE_W-1:0]  line_reg, line_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic [LINE_W-1:0]  row_reg, row_next;
   logic               frame_done_reg, frame_done_next;

   logic shift_load;
   logic shift_run;
   logic shift_last;

   assign shift_load = (state_reg == ST_RD_CAP);
   assign shift_run  = (state_reg == ST_SHIFT);

   led_byte_shifter u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (shift_load),
      .run      (shift_run),
      .data     (ram_dout),
      .sdi      (led_sdi),
      .sclk     (led_sclk),
      .last_bit (shift_last)
   );

   // Sequencer state and scan position registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         col_reg        <= '0;
         line_reg       <= '0;
         dwell_reg      <= '0;
         row_reg        <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         col_reg        <= col_next;
         line_reg       <= line_next;
         dwell_reg      <= dwell_next;
         row_reg        <= row_next;
         frame_done_reg <= frame_done_next;
      end
   end

   // Next-state logic: read each column byte, shift it, latch, then dwell.
   // hold is only honoured in IDLE and on the final dwell cycle.
   always_comb begin
      state_next      = state_reg;
      col_next        = col_reg;
      line_next       = line_reg;
      dwell_next      = dwell_reg;
      row_next        = row_reg;
      frame_done_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!hold) state_next = ST_RD_ADDR;
         end
         ST_RD_ADDR: begin
            state_next = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (shift_last) begin
               if (col_reg == COL_LAST) begin
                  col_next   = '0;
                  state_next = ST_LATCH;
               end else begin
                  col_next   = col_reg + COL_W'(1);
                  state_next = ST_RD_ADDR;
               end
            end
         end
         ST_LATCH: begin
            row_next   = line_reg;
            dwell_next = '0;
            state_next = ST_DWELL;
         end
         ST_DWELL: begin
            if (dwell_reg == DWELL_LAST) begin
               line_next       = line_reg + LINE_W'(1);
               frame_done_next = (line_reg == LINE_LAST);
               state_next      = hold ? ST_IDLE : ST_RD_ADDR;
            end else begin
               dwell_next = dwell_reg + DWELL_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign ram_clk    = (state_reg == ST_RD_ADDR);
   assign ram_addr   = fb_addr(col_reg, line_reg);
   assign led_lat    = (state_reg == ST_LATCH);
   assign led_row    = row_reg;
   assign idle       = (state_reg == ST_IDLE);
   assign frame_done = frame_done_reg;

`ifdef FB_SCAN_BLANK_EN
   // Dark while parked, and across the row change (latch plus first dwell).
   assign led_oe_n = (state_reg == ST_IDLE) ||
                     (state_reg == ST_LATCH) ||
                     ((state_reg == ST_DWELL) && (dwell_reg == '0));
`else
   // The previously latched row stays lit whenever the scanner is running.
   assign led_oe_n = (state_reg == ST_IDLE);
`endif

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: a RAM model feeds the reader, a monitor collects
// addresses, pixels, latches and pulses, and each test compares them with
// expectations derived from the framebuffer contents and line timing.
module tb_fb_scan_reader;

   localparam int DW     = 4;
   localparam int LINE_P = 145 + DW;
`ifdef FB_SCAN_BLANK_EN
   localparam int OE_PER_LINE = 2;
`else
   localparam int OE_PER_LINE = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hold = 1'b1;
   logic [7:0] ram_dout = 8'h00;
   logic       ram_clk;
   logic [7:0] ram_addr;
   logic       led_sdi, led_sclk, led_lat, led_oe_n;
   logic [4:0] led_row;
   logic       idle, frame_done;

   always #5 clk = ~clk;

   fb_scan_reader #(.DWELL_CYCLES(DW), .DWELL_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .hold       (hold),
      .ram_dout   (ram_dout),
      .ram_clk    (ram_clk),
      .ram_addr   (ram_addr),
      .led_sdi    (led_sdi),
      .led_sclk   (led_sclk),
      .led_lat    (led_lat),
      .led_oe_n   (led_oe_n),
      .led_row    (led_row),
      .idle       (idle),
      .frame_done (frame_done)
   );

   // Framebuffer RAM model: data appears the cycle after the ram_clk cycle.
   logic [7:0] mem [256];
   always @(posedge clk) if (ram_clk) ram_dout <= mem[ram_addr];

   int total = 0;
   int bad   = 0;

   // Monitor state, sampled 1 time unit after each rising edge.
   int         cyc = 0;
   int         t_fall = -1;
   int         t_rise = -1;
   int         oe_hi = 0;
   logic       idle_prev = 1'b1;
   logic       sclk_prev = 1'b0;
   logic       lat_prev = 1'b0;
   logic [7:0] addr_q[$];
   bit         pix_q[$];
   int         lat_cyc_q[$];
   logic [4:0] row_q[$];
   int         fd_cyc_q[$];

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (ram_clk) addr_q.push_back(ram_addr);
      if (led_sclk && !sclk_prev) pix_q.push_back(led_sdi);
      if (led_lat) lat_cyc_q.push_back(cyc);
      if (lat_prev) row_q.push_back(led_row);
      if (frame_done) fd_cyc_q.push_back(cyc);
      if (led_oe_n && !idle) oe_hi = oe_hi + 1;
      if (!idle && idle_prev) t_fall = cyc;
      if (idle && !idle_prev) t_rise = cyc;
      idle_prev = idle;
      sclk_prev = led_sclk;
      lat_prev  = led_lat;
   end

   task automatic clear_mon();
      addr_q.delete();
      pix_q.delete();
      lat_cyc_q.delete();
      row_q.delete();
      fd_cyc_q.delete();
      oe_hi  = 0;
      t_fall = -1;
      t_rise = -1;
   endtask

   // Pixel k of line l: byte at column k/8, bit 7 first.
   function automatic logic [63:0] exp_line(int l);
      logic [63:0] v;
      logic [7:0]  b;
      v = '0;
      for (int k = 0; k < 64; k++) begin
         b = mem[{3'(k / 8), 5'(l)}];
         v[63 - k] = b[7 - (k % 8)];
      end
      return v;
   endfunction

   function automatic logic [63:0] act_line(int l);
      logic [63:0] v;
      v = 'x;
      for (int k = 0; k < 64; k++)
         if (64 * l + k < pix_q.size()) v[63 - k] = pix_q[64 * l + k];
      return v;
   endfunction

   function automatic logic [63:0] exp_addrs(int l);
      logic [63:0] v;
      for (int c = 0; c < 8; c++) v[63 - 8 * c -: 8] = {3'(c), 5'(l)};
      return v;
   endfunction

   function automatic logic [63:0] act_addrs(int l);
      logic [63:0] v;
      v = 'x;
      for (int c = 0; c < 8; c++)
         if (8 * l + c < addr_q.size()) v[63 - 8 * c -: 8] = addr_q[8 * l + c];
      return v;
   endfunction

   // Reset with hold high, then release with hold low and wait for idle to fall.
   task automatic start_scan();
      rst  = 1'b0;
      hold = 1'b1;
      repeat (2) @(negedge clk);
      clear_mon();
      rst  = 1'b1;
      hold = 1'b0;
      for (int i = 0; i < 10 && t_fall < 0; i++) @(negedge clk);
      if (t_fall < 0) begin
         total++; bad++;
         $display("FAIL start: idle still %0b, required 0", idle);
      end
   endtask

   task automatic test_reset();
      logic [19:0] got;
      rst  = 1'b0;
      hold = 1'(($urandom & 1));
      repeat (2) @(negedge clk);
      got = {ram_clk, ram_addr, led_sdi, led_sclk, led_lat, led_oe_n, led_row, idle, frame_done};
      total++;
      if (got !== 20'b0_00000000_0_0_0_1_00000_1_0) begin
         bad++;
         $display("FAIL reset_values: got %05h required %05h", got, 20'b0_00000000_0_0_0_1_00000_1_0);
      end
      clear_mon();
      hold = 1'b1;
      rst  = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (addr_q.size() !== 0 || idle !== 1'b1) begin
         bad++;
         $display("FAIL parked_after_reset: reads=%0d idle=%0b required 0 reads idle=1", addr_q.size(), idle);
      end
      $display("test_reset: done");
   endtask

   task automatic test_first_line();
      logic [63:0] pix;
      for (int a = 0; a < 256; a++) mem[a] = 8'(a);
      start_scan();
      for (int i = 0; i < 400 && row_q.size() < 1; i++) @(negedge clk);
      total++;
      if (row_q.size() < 1) begin
         bad++;
         $display("FAIL first_line_timeout: latches=0 required 1");
         return;
      end
      total++;
      if (act_addrs(0) !== exp_addrs(0)) begin
         bad++;
         $display("FAIL first_addrs: got %016h required %016h", act_addrs(0), exp_addrs(0));
      end
      pix = act_line(0);
      total++;
      if (pix[55:48] !== 8'h20) begin
         bad++;
         $display("FAIL col1_bits: got %02h required 20", pix[55:48]);
      end
      total++;
      if (pix !== exp_line(0)) begin
         bad++;
         $display("FAIL first_pixels: got %016h required %016h", pix, exp_line(0));
      end
      total++;
      if (lat_cyc_q[0] - t_fall !== 144) begin
         bad++;
         $display("FAIL latch_time: got offset %0d required 144", lat_cyc_q[0] - t_fall);
      end
      total++;
      if (row_q[0] !== 5'd0) begin
         bad++;
         $display("FAIL first_row: got %0d required 0", row_q[0]);
      end
      $display("test_first_line: addrs=%0d pixels=%0d", addr_q.size(), pix_q.size());
   endtask

   task automatic test_edge_pixels();
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      for (int c = 0; c < 8; c++) mem[{3'(c), 5'd0}] = 8'h00;
      mem[{3'd0, 5'd0}] = 8'h80;
      mem[{3'd7, 5'd0}] = 8'h01;
      start_scan();
      for (int i = 0; i < 400 && row_q.size() < 1; i++) @(negedge clk);
      total++;
      if (act_line(0) !== 64'h8000_0000_0000_0001) begin
         bad++;
         $display("FAIL edge_pixels: got %016h required 8000000000000001", act_line(0));
      end
      $display("test_edge_pixels: done");
   endtask

   task automatic test_random_lines();
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      start_scan();
      for (int i = 0; i < 5 * LINE_P && row_q.size() < 4; i++) @(negedge clk);
      total++;
      if (row_q.size() < 4) begin
         bad++;
         $display("FAIL random_timeout: latches=%0d required 4", row_q.size());
         return;
      end
      for (int l = 0; l < 4; l++) begin
         total++;
         if (act_addrs(l) !== exp_addrs(l)) begin
            bad++;
            $display("FAIL rand_addrs line %0d: got %016h required %016h", l, act_addrs(l), exp_addrs(l));
         end
         total++;
         if (act_line(l) !== exp_line(l)) begin
            bad++;
            $display("FAIL rand_pixels line %0d: got %016h required %016h", l, act_line(l), exp_line(l));
         end
         total++;
         if (row_q[l] !== 5'(l)) begin
            bad++;
            $display("FAIL rand_row line %0d: got %0d required %0d", l, row_q[l], l);
         end
         $display("test_random_lines: line %0d checked", l);
      end
   endtask

   task automatic test_hold();
      start_scan();
      for (int i = 0; i < 1000 && (cyc - t_fall) < 3 * LINE_P + 50; i++) @(negedge clk);
      hold = 1'b1;
      for (int i = 0; i < 400 && t_rise < 0; i++) @(negedge clk);
      total++;
      if (t_rise - t_fall !== 4 * LINE_P) begin
         bad++;
         $display("FAIL hold_idle_time: got offset %0d required %0d", t_rise - t_fall, 4 * LINE_P);
      end
      total++;
      if (row_q.size() !== 4 || row_q[3] !== 5'd3) begin
         bad++;
         $display("FAIL hold_rows: got %0d latches required 4 ending at row 3", row_q.size());
      end
      addr_q.delete();
      repeat (100) @(negedge clk);
      total++;
      if (addr_q.size() !== 0 || idle !== 1'b1) begin
         bad++;
         $display("FAIL hold_parked: reads=%0d idle=%0b required 0 reads idle=1", addr_q.size(), idle);
      end
      hold = 1'b0;
      for (int i = 0; i < 10 && addr_q.size() < 1; i++) @(negedge clk);
      total++;
      if (addr_q.size() < 1 || addr_q[0] !== 8'h04) begin
         bad++;
         $display("FAIL resume_addr: got %02h required 04", addr_q.size() > 0 ? addr_q[0] : 8'hxx);
      end
      $display("test_hold: idle at offset %0d", t_rise - t_fall);
   endtask

   task automatic test_reset_mid();
      logic [19:0] got;
      start_scan();
      for (int i = 0; i < 2000 && (cyc - t_fall) < 10 * LINE_P + 5 * 18 + 6; i++) @(negedge clk);
      total++;
      if (addr_q.size() < 1 || addr_q[addr_q.size() - 1] !== 8'hAA) begin
         bad++;
         $display("FAIL mid_position: got %02h required aa", addr_q.size() > 0 ? addr_q[addr_q.size() - 1] : 8'hxx);
      end
      rst = 1'b0;
      #1;
      got = {ram_clk, ram_addr, led_sdi, led_sclk, led_lat, led_oe_n, led_row, idle, frame_done};
      total++;
      if (got !== 20'b0_00000000_0_0_0_1_00000_1_0) begin
         bad++;
         $display("FAIL mid_reset_values: got %05h required %05h", got, 20'b0_00000000_0_0_0_1_00000_1_0);
      end
      @(negedge clk);
      clear_mon();
      rst = 1'b1;
      for (int i = 0; i < 10 && addr_q.size() < 1; i++) @(negedge clk);
      total++;
      if (addr_q.size() < 1 || addr_q[0] !== 8'h00) begin
         bad++;
         $display("FAIL restart_addr: got %02h required 00", addr_q.size() > 0 ? addr_q[0] : 8'hxx);
      end
      $display("test_reset_mid: done");
   endtask

   task automatic test_frame();
      start_scan();
      for (int i = 0; i < 10000 && fd_cyc_q.size() < 2; i++) @(negedge clk);
      total++;
      if (fd_cyc_q.size() < 2) begin
         bad++;
         $display("FAIL frame_timeout: pulses=%0d required 2", fd_cyc_q.size());
         return;
      end
      total++;
      if (fd_cyc_q[0] - t_fall !== 32 * LINE_P) begin
         bad++;
         $display("FAIL frame_first: got offset %0d required %0d", fd_cyc_q[0] - t_fall, 32 * LINE_P);
      end
      total++;
      if (fd_cyc_q[1] - fd_cyc_q[0] !== 32 * LINE_P) begin
         bad++;
         $display("FAIL frame_period: got %0d required %0d", fd_cyc_q[1] - fd_cyc_q[0], 32 * LINE_P);
      end
      total++;
      if (row_q.size() < 33 || row_q[31] !== 5'd31 || row_q[32] !== 5'd0) begin
         bad++;
         $display("FAIL row_wrap: latches=%0d required rows 31 then 0", row_q.size());
      end
      total++;
      if (oe_hi !== 64 * OE_PER_LINE) begin
         bad++;
         $display("FAIL oe_blank: got %0d dark cycles required %0d", oe_hi, 64 * OE_PER_LINE);
      end
      $display("test_frame: period %0d", fd_cyc_q[1] - fd_cyc_q[0]);
   endtask

   initial begin
      test_reset();
      test_first_line();
      test_edge_pixels();
      test_random_lines();
      test_hold();
      test_reset_mid();
      test_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
